// File: rtl/controller_mode_arbiter.sv
// Routes one of NumEngines standby engines to the shared TTI queues and bus events.
// Ownership changes only through a drain/quiet handover, so a mode change never splits a transfer.
module controller_mode_arbiter #(
    parameter int unsigned NumEngines      = 2,
    parameter int unsigned SelWidth        = $clog2(NumEngines),
    parameter int unsigned RxDescDataWidth = 32,
    parameter int unsigned RxDataWidth     = 8,
    parameter int unsigned QuietCycles     = 4,
    parameter int unsigned DrainTimeout    = 1024,
    parameter int unsigned ResetEngine     = 0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [SelWidth-1:0]                   mode_req_i,
    input  logic [NumEngines-1:0]                 eng_busy_i,
    input  logic [NumEngines-1:0]                 eng_rx_desc_wvalid_i,
    input  logic [NumEngines*RxDescDataWidth-1:0] eng_rx_desc_wdata_i,
    input  logic [NumEngines-1:0]                 eng_rx_wvalid_i,
    input  logic [NumEngines*RxDataWidth-1:0]     eng_rx_wdata_i,
    input  logic [NumEngines-1:0]                 eng_tx_desc_rready_i,
    input  logic [NumEngines-1:0]                 eng_tx_rready_i,
    input  logic [NumEngines-1:0]                 eng_bus_stop_i,
    input  logic                                  rx_desc_wready_i,
    input  logic                                  rx_wready_i,
    input  logic                                  tx_desc_rvalid_i,
    input  logic                                  tx_rvalid_i,
    output logic                                  rx_desc_wvalid_o,
    output logic [RxDescDataWidth-1:0]            rx_desc_wdata_o,
    output logic                                  rx_wvalid_o,
    output logic [RxDataWidth-1:0]                rx_wdata_o,
    output logic                                  tx_desc_rready_o,
    output logic                                  tx_rready_o,
    output logic                                  bus_stop_o,
    output logic [NumEngines-1:0]                 eng_rx_desc_wready_o,
    output logic [NumEngines-1:0]                 eng_rx_wready_o,
    output logic [NumEngines-1:0]                 eng_tx_desc_rvalid_o,
    output logic [NumEngines-1:0]                 eng_tx_rvalid_o,
    output logic [NumEngines-1:0]                 eng_en_o,
    output logic [SelWidth-1:0]                   active_sel_o,
    output logic                                  switch_pending_o,
    output logic                                  switch_timeout_o,
    output logic                                  req_err_o
);

    localparam int unsigned DcW = $clog2(DrainTimeout + 1);
    localparam int unsigned QcW = $clog2(QuietCycles + 1);
    localparam logic [SelWidth-1:0] ResetSel = SelWidth'(ResetEngine);

    typedef enum logic [1:0] {StActive, StDrain, StQuiet} state_e;

    state_e              state_q, state_d;
    logic [SelWidth-1:0] active_sel_q, active_sel_d;
    logic [SelWidth-1:0] target_q, target_d;
    logic [DcW-1:0]      drain_cnt_q, drain_cnt_d;
    logic [QcW-1:0]      quiet_cnt_q, quiet_cnt_d;
    logic                switch_timeout_q, switch_timeout_d;
    logic                req_err_q, req_err_d;

    logic                  routed;
    logic                  req_valid;
    logic [NumEngines-1:0] sel_oh;
    logic [NumEngines-1:0] busy_sh;

    // Selection uses shifts rather than bit-selects so SelWidth may exceed $clog2(NumEngines).
    assign routed    = (state_q != StQuiet);
    assign req_valid = (32'(mode_req_i) < NumEngines);
    assign sel_oh    = NumEngines'(1) << active_sel_q;
    assign busy_sh   = eng_busy_i >> active_sel_q;

    assign rx_desc_wvalid_o = routed && |(eng_rx_desc_wvalid_i & sel_oh);
    assign rx_wvalid_o      = routed && |(eng_rx_wvalid_i & sel_oh);
    assign tx_desc_rready_o = routed && |(eng_tx_desc_rready_i & sel_oh);
    assign tx_rready_o      = routed && |(eng_tx_rready_i & sel_oh);
    assign bus_stop_o       = routed && |(eng_bus_stop_i & sel_oh);
    assign rx_desc_wdata_o  = RxDescDataWidth'(eng_rx_desc_wdata_i >> (active_sel_q * RxDescDataWidth));
    assign rx_wdata_o       = RxDataWidth'(eng_rx_wdata_i >> (active_sel_q * RxDataWidth));

    assign eng_en_o             = routed ? sel_oh : '0;
    assign eng_rx_desc_wready_o = eng_en_o & {NumEngines{rx_desc_wready_i}};
    assign eng_rx_wready_o      = eng_en_o & {NumEngines{rx_wready_i}};
    assign eng_tx_desc_rvalid_o = eng_en_o & {NumEngines{tx_desc_rvalid_i}};
    assign eng_tx_rvalid_o      = eng_en_o & {NumEngines{tx_rvalid_i}};

    assign active_sel_o     = active_sel_q;
    assign switch_pending_o = (state_q != StActive);
    assign switch_timeout_o = switch_timeout_q;
    assign req_err_o        = req_err_q;

    always_comb begin
        state_d          = state_q;
        active_sel_d     = active_sel_q;
        target_d         = target_q;
        drain_cnt_d      = drain_cnt_q;
        quiet_cnt_d      = quiet_cnt_q;
        switch_timeout_d = 1'b0;
        req_err_d        = !req_valid;
        case (state_q)
            StActive: begin
                if (req_valid && (mode_req_i != active_sel_q)) begin
                    target_d    = mode_req_i;
                    drain_cnt_d = '0;
                    state_d     = StDrain;
                end
            end
            StDrain: begin
                if (drain_cnt_q != DcW'(DrainTimeout - 1)) begin
                    drain_cnt_d = drain_cnt_q + DcW'(1);
                end
                if (req_valid && (mode_req_i != active_sel_q)) begin
                    target_d = mode_req_i;
                end
                // Timeout wins over abort; abort wins over a clean idle exit.
                if (drain_cnt_q == DcW'(DrainTimeout - 1)) begin
                    state_d          = StQuiet;
                    quiet_cnt_d      = '0;
                    switch_timeout_d = 1'b1;
                end else if (mode_req_i == active_sel_q) begin
                    state_d = StActive;
                end else if (!busy_sh[0] && !rx_desc_wvalid_o && !rx_wvalid_o) begin
                    state_d     = StQuiet;
                    quiet_cnt_d = '0;
                end
            end
            StQuiet: begin
                if (quiet_cnt_q == QcW'(QuietCycles - 1)) begin
                    active_sel_d = target_q;
                    state_d      = StActive;
                end else begin
                    quiet_cnt_d = quiet_cnt_q + QcW'(1);
                end
            end
            default: state_d = StActive;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q          <= StActive;
            active_sel_q     <= ResetSel;
            target_q         <= ResetSel;
            drain_cnt_q      <= '0;
            quiet_cnt_q      <= '0;
            switch_timeout_q <= 1'b0;
            req_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            active_sel_q     <= active_sel_d;
            target_q         <= target_d;
            drain_cnt_q      <= drain_cnt_d;
            quiet_cnt_q      <= quiet_cnt_d;
            switch_timeout_q <= switch_timeout_d;
            req_err_q        <= req_err_d;
        end
    end

endmodule

// File: tb/tb_controller_mode_arbiter.sv
// Self-checking bench for controller_mode_arbiter: four engines, random traffic against a
// handover model kept as owner / draining flag / quiet countdown.
module tb_controller_mode_arbiter;

    localparam int N  = 4;
    localparam int SW = 3;
    localparam int DW = 32;
    localparam int RW = 8;
    localparam int QC = 4;
    localparam int DT = 16;
    localparam int VW = 71;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic [SW-1:0]     mode_req_i;
    logic [N-1:0]      eng_busy_i;
    logic [N-1:0]      eng_rx_desc_wvalid_i;
    logic [N*DW-1:0]   eng_rx_desc_wdata_i;
    logic [N-1:0]      eng_rx_wvalid_i;
    logic [N*RW-1:0]   eng_rx_wdata_i;
    logic [N-1:0]      eng_tx_desc_rready_i;
    logic [N-1:0]      eng_tx_rready_i;
    logic [N-1:0]      eng_bus_stop_i;
    logic              rx_desc_wready_i, rx_wready_i, tx_desc_rvalid_i, tx_rvalid_i;
    logic              rx_desc_wvalid_o;
    logic [DW-1:0]     rx_desc_wdata_o;
    logic              rx_wvalid_o;
    logic [RW-1:0]     rx_wdata_o;
    logic              tx_desc_rready_o, tx_rready_o, bus_stop_o;
    logic [N-1:0]      eng_rx_desc_wready_o, eng_rx_wready_o, eng_tx_desc_rvalid_o, eng_tx_rvalid_o;
    logic [N-1:0]      eng_en_o;
    logic [SW-1:0]     active_sel_o;
    logic              switch_pending_o, switch_timeout_o, req_err_o;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the queues, whether a handover is draining, quiet cycles left.
    int m_owner, m_target, m_quiet_left, m_age;
    bit m_draining, m_tmo, m_err;

    always #5 clk = ~clk;

    controller_mode_arbiter #(
        .NumEngines(N), .SelWidth(SW), .RxDescDataWidth(DW), .RxDataWidth(RW),
        .QuietCycles(QC), .DrainTimeout(DT), .ResetEngine(0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .mode_req_i(mode_req_i), .eng_busy_i(eng_busy_i),
        .eng_rx_desc_wvalid_i(eng_rx_desc_wvalid_i), .eng_rx_desc_wdata_i(eng_rx_desc_wdata_i),
        .eng_rx_wvalid_i(eng_rx_wvalid_i), .eng_rx_wdata_i(eng_rx_wdata_i),
        .eng_tx_desc_rready_i(eng_tx_desc_rready_i), .eng_tx_rready_i(eng_tx_rready_i),
        .eng_bus_stop_i(eng_bus_stop_i), .rx_desc_wready_i(rx_desc_wready_i),
        .rx_wready_i(rx_wready_i), .tx_desc_rvalid_i(tx_desc_rvalid_i), .tx_rvalid_i(tx_rvalid_i),
        .rx_desc_wvalid_o(rx_desc_wvalid_o), .rx_desc_wdata_o(rx_desc_wdata_o),
        .rx_wvalid_o(rx_wvalid_o), .rx_wdata_o(rx_wdata_o), .tx_desc_rready_o(tx_desc_rready_o),
        .tx_rready_o(tx_rready_o), .bus_stop_o(bus_stop_o),
        .eng_rx_desc_wready_o(eng_rx_desc_wready_o), .eng_rx_wready_o(eng_rx_wready_o),
        .eng_tx_desc_rvalid_o(eng_tx_desc_rvalid_o), .eng_tx_rvalid_o(eng_tx_rvalid_o),
        .eng_en_o(eng_en_o), .active_sel_o(active_sel_o), .switch_pending_o(switch_pending_o),
        .switch_timeout_o(switch_timeout_o), .req_err_o(req_err_o)
    );

    function automatic logic [VW-1:0] obs_vec();
        return {rx_desc_wvalid_o, rx_desc_wdata_o, rx_wvalid_o, rx_wdata_o, tx_desc_rready_o,
                tx_rready_o, bus_stop_o, eng_rx_desc_wready_o, eng_rx_wready_o,
                eng_tx_desc_rvalid_o, eng_tx_rvalid_o, eng_en_o, active_sel_o,
                switch_pending_o, switch_timeout_o, req_err_o};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic       routed;
        logic [3:0] oh;
        int         o;
        routed = (m_quiet_left == 0);
        o      = m_owner;
        oh     = routed ? 4'(1 << o) : 4'b0000;
        return {routed & eng_rx_desc_wvalid_i[o], eng_rx_desc_wdata_i[o*DW +: DW],
                routed & eng_rx_wvalid_i[o], eng_rx_wdata_i[o*RW +: RW],
                routed & eng_tx_desc_rready_i[o], routed & eng_tx_rready_i[o],
                routed & eng_bus_stop_i[o], oh & {4{rx_desc_wready_i}}, oh & {4{rx_wready_i}},
                oh & {4{tx_desc_rvalid_i}}, oh & {4{tx_rvalid_i}}, oh, 3'(o),
                m_draining | !routed, m_tmo, m_err};
    endfunction

    function automatic void model_step();
        int  req;
        bit  valid;
        req   = int'(mode_req_i);
        valid = (req < N);
        if (!rst_ni) begin
            m_owner = 0; m_target = 0; m_quiet_left = 0; m_age = 0;
            m_draining = 0; m_tmo = 0; m_err = 0;
            return;
        end
        m_err = !valid;
        m_tmo = 0;
        if (m_quiet_left > 0) begin
            m_quiet_left--;
            if (m_quiet_left == 0) m_owner = m_target;
        end else if (m_draining) begin
            if (valid && req != m_owner) m_target = req;
            if (m_age == DT - 1) begin
                m_tmo = 1; m_draining = 0; m_quiet_left = QC;
            end else if (req == m_owner) begin
                m_draining = 0;
            end else if (!eng_busy_i[m_owner] && !eng_rx_desc_wvalid_i[m_owner] &&
                         !eng_rx_wvalid_i[m_owner]) begin
                m_draining = 0; m_quiet_left = QC;
            end else begin
                m_age++;
            end
        end else if (valid && req != m_owner) begin
            m_target = req; m_draining = 1; m_age = 0;
        end
    endfunction

    task automatic advance();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_bus(input logic [N-1:0] vmask);
        eng_rx_desc_wvalid_i = 4'($urandom) & vmask;
        eng_rx_wvalid_i      = 4'($urandom) & vmask;
        for (int k = 0; k < N; k++) begin
            eng_rx_desc_wdata_i[k*DW +: DW] = $urandom;
            eng_rx_wdata_i[k*RW +: RW]      = 8'($urandom);
        end
        eng_tx_desc_rready_i = 4'($urandom);
        eng_tx_rready_i      = 4'($urandom);
        eng_bus_stop_i       = 4'($urandom);
        rx_desc_wready_i     = 1'($urandom);
        rx_wready_i          = 1'($urandom);
        tx_desc_rvalid_i     = 1'($urandom);
        tx_rvalid_i          = 1'($urandom);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; mode_req_i = '0; eng_busy_i = '0;
        rand_bus(4'hF);
        advance();
        advance();
        rand_bus(4'h0);
        eng_rx_wvalid_i = 4'b0001;
        eng_rx_wdata_i[7:0] = 8'hA5;
        #1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_vec actual %h required %h", obs_vec(), exp_vec());
        end
        checks++;
        if ({eng_en_o, active_sel_o, switch_pending_o, switch_timeout_o, req_err_o, rx_wvalid_o, rx_wdata_o}
            !== {4'b0001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL reset_state actual en=%b sel=%0d pend=%b tmo=%b err=%b rxv=%b rxd=%h required en=0001 sel=0 pend=0 tmo=0 err=0 rxv=1 rxd=a5",
                     eng_en_o, active_sel_o, switch_pending_o, switch_timeout_o, req_err_o, rx_wvalid_o, rx_wdata_o);
        end
        rst_ni = 1'b1;
        advance();
    endtask

    task automatic test_switch();
        int  drain_n = 0, quiet_n = 0;
        bit  done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            mode_req_i = 3'd2;
            eng_busy_i = (k < 10) ? 4'b0001 : 4'b0000;
            rand_bus(4'h0);
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL switch_vec cyc %0d actual %h required %h", k, obs_vec(), exp_vec());
            end
            if (switch_pending_o && eng_en_o != 0) drain_n++;
            if (eng_en_o == 0) quiet_n++;
            if (active_sel_o == 3'd2 && !switch_pending_o) done = 1;
            else advance();
        end
        checks++;
        if (drain_n != 10 || quiet_n != QC) begin
            errors++; $display("FAIL switch_len actual drain=%0d quiet=%0d required drain=10 quiet=%0d", drain_n, quiet_n, QC);
        end
        checks++;
        if (eng_en_o !== 4'b0100 || active_sel_o !== 3'd2) begin
            errors++; $display("FAIL switch_final actual en=%b sel=%0d required en=0100 sel=2", eng_en_o, active_sel_o);
        end
        advance();
    endtask

    task automatic test_abort();
        int drops = 0, tmos = 0;
        for (int k = 0; k < 7; k++) begin
            mode_req_i = (k < 3) ? 3'd3 : 3'd2;
            eng_busy_i = 4'b0100;
            rand_bus(4'h0);
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL abort_vec cyc %0d actual %h required %h", k, obs_vec(), exp_vec());
            end
            if (eng_en_o !== 4'b0100) drops++;
            if (switch_timeout_o) tmos++;
            advance();
        end
        checks++;
        if (drops != 0 || tmos != 0 || switch_pending_o !== 1'b0 || active_sel_o !== 3'd2) begin
            errors++;
            $display("FAIL abort actual drops=%0d tmo=%0d pend=%b sel=%0d required drops=0 tmo=0 pend=0 sel=2",
                     drops, tmos, switch_pending_o, active_sel_o);
        end
    endtask

    task automatic test_req_err();
        int errs = 0, leaks = 0, pend = 0;
        for (int k = 0; k < 9; k++) begin
            mode_req_i = (k < 8) ? 3'($urandom_range(4, 7)) : 3'd2;
            if (k == 0) mode_req_i = 3'd5;
            eng_busy_i = 4'($urandom);
            rand_bus(4'h0);
            eng_rx_wvalid_i = 4'b0010;
            rx_wready_i     = 1'b1;
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL req_err_vec cyc %0d actual %h required %h", k, obs_vec(), exp_vec());
            end
            if (req_err_o) errs++;
            if (rx_wvalid_o || eng_rx_wready_o[1]) leaks++;
            if (switch_pending_o) pend++;
            advance();
        end
        checks++;
        if (errs != 8 || leaks != 0 || pend != 0 || active_sel_o !== 3'd2) begin
            errors++;
            $display("FAIL req_err actual errs=%0d leaks=%0d pend=%0d sel=%0d required errs=8 leaks=0 pend=0 sel=2",
                     errs, leaks, pend, active_sel_o);
        end
    endtask

    task automatic test_timeout();
        int entry = -1, pulses = 0, at = -1;
        bit done = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            mode_req_i = 3'd1;
            eng_busy_i = 4'b0100;
            rand_bus(4'h0);
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL timeout_vec cyc %0d actual %h required %h", k, obs_vec(), exp_vec());
            end
            if (switch_pending_o && entry < 0) entry = k;
            if (switch_timeout_o) begin pulses++; at = k; end
            if (active_sel_o == 3'd1 && !switch_pending_o) done = 1;
            else advance();
        end
        checks++;
        if (pulses != 1 || at - entry != DT || active_sel_o !== 3'd1) begin
            errors++;
            $display("FAIL timeout actual pulses=%0d delay=%0d sel=%0d required pulses=1 delay=%0d sel=1",
                     pulses, at - entry, active_sel_o, DT);
        end
        advance();
    endtask

    task automatic test_reset_in_quiet();
        bit hit = 0;
        for (int k = 0; k < 10 && !hit; k++) begin
            mode_req_i = 3'd3;
            eng_busy_i = 4'b0000;
            rand_bus(4'h0);
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL rstq_vec cyc %0d actual %h required %h", k, obs_vec(), exp_vec());
            end
            if (eng_en_o == 0) begin
                hit = 1;
                rst_ni = 1'b0;
                mode_req_i = 3'd0;
            end
            advance();
        end
        #1;
        checks++;
        if (!hit || {eng_en_o, active_sel_o, switch_pending_o} !== {4'b0001, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL rst_in_quiet actual hit=%b en=%b sel=%0d pend=%b required hit=1 en=0001 sel=0 pend=0",
                     hit, eng_en_o, active_sel_o, switch_pending_o);
        end
        rst_ni = 1'b1;
        advance();
    endtask

    task automatic test_random();
        logic [SW-1:0] req_cur = '0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 7) == 0) req_cur = 3'($urandom_range(0, 7));
            mode_req_i = req_cur;
            eng_busy_i = 4'($urandom) & 4'($urandom);
            rst_ni     = ($urandom_range(0, 199) != 0);
            rand_bus(4'($urandom) & 4'($urandom));
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_vec cyc %0d actual %h required %h", k, obs_vec(), exp_vec());
            end
            advance();
        end
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0;
        mode_req_i = '0;
        eng_busy_i = '0;
        rand_bus(4'h0);
        @(negedge clk);
        test_reset();
        test_switch();
        test_abort();
        test_req_err();
        test_timeout();
        test_reset_in_quiet();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controller_mode_arbiter.md
Name: controller_mode_arbiter

Overview:
- Generalised successor to the fixed two-engine I2C/I3C standby mux.
- Connects one of NumEngines standby protocol engines to the shared TTI queues (RX descriptor, RX data, TX descriptor, TX data) and to the bus event outputs.
- Unlike a static combinational select, it changes ownership only through a drain/quiet handover state machine, so a mode change in the middle of a transaction cannot corrupt the queues.
- Sits between the standby engines and the TTI queue block inside controller_standby.

Parameters:
- NumEngines, 2, number of engines; must be >= 2.
- SelWidth, $clog2(NumEngines), width of engine index.
- RxDescDataWidth, 32, RX descriptor width.
- RxDataWidth, 8, RX data width.
- QuietCycles, 4, cycles with every engine disabled during a handover; must be >= 1.
- DrainTimeout, 1024, maximum cycles spent in DRAIN.
- ResetEngine, 0, engine that owns the queues after reset.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- mode_req_i  in  SelWidth  requested owning engine.
- eng_busy_i  in  NumEngines  per-engine "transaction in progress".
- eng_rx_desc_wvalid_i  in  NumEngines  per-engine RX descriptor valid.
- eng_rx_desc_wdata_i  in  NumEngines*RxDescDataWidth  RX descriptor data; engine k occupies slice k.
- eng_rx_wvalid_i  in  NumEngines  per-engine RX data valid.
- eng_rx_wdata_i  in  NumEngines*RxDataWidth  RX data; engine k occupies slice k.
- eng_tx_desc_rready_i  in  NumEngines  per-engine TX descriptor ready.
- eng_tx_rready_i  in  NumEngines  per-engine TX data ready.
- eng_bus_stop_i  in  NumEngines  per-engine STOP pulse.
- rx_desc_wready_i, rx_wready_i, tx_desc_rvalid_i, tx_rvalid_i  in  1 each  handshakes from the queues.
- rx_desc_wvalid_o  out  1  muxed RX descriptor valid.
- rx_desc_wdata_o  out  RxDescDataWidth  muxed RX descriptor data.
- rx_wvalid_o  out  1  muxed RX data valid.
- rx_wdata_o  out  RxDataWidth  muxed RX data.
- tx_desc_rready_o, tx_rready_o, bus_stop_o  out  1 each  muxed outputs.
- eng_rx_desc_wready_o, eng_rx_wready_o, eng_tx_desc_rvalid_o, eng_tx_rvalid_o  out  NumEngines each  queue handshakes routed back to the engines.
- eng_en_o  out  NumEngines  one-hot engine enable.
- active_sel_o  out  SelWidth  current owning engine.
- switch_pending_o  out  1  high in DRAIN or QUIET.
- switch_timeout_o  out  1  one-cycle pulse when DRAIN times out.
- req_err_o  out  1  one-cycle pulse when mode_req_i >= NumEngines.

Behaviour:
- All state is registered on the clk_i rising edge. Muxing itself is combinational from the registered owner index (active_sel) and state, so it adds no data latency.
- Reset (rst_ni=0 at a clock edge):
  - state=ACTIVE, active_sel=ResetEngine, target=ResetEngine, counters=0.
  - eng_en_o=one-hot(ResetEngine).
  - switch_pending_o=0, switch_timeout_o=0, req_err_o=0.
  - All muxed outputs follow ResetEngine.
- Routing in ACTIVE and DRAIN:
  - Queue-side outputs are taken from engine active_sel.
  - The back-handshakes go to active_sel only; every other engine's bit is 0.
- Routing in QUIET: all queue-side valid/ready outputs, bus_stop_o and all eng_* handshake bits are 0. Data outputs hold the last owner's data (don't-care).
- eng_en_o:
  - one-hot(active_sel) in ACTIVE and DRAIN;
  - all-zero in QUIET.
- req_err_o: mode_req_i >= NumEngines pulses req_err_o for one cycle and is otherwise ignored. While an invalid request persists, req_err_o stays high every cycle.
- State machine:
  - ACTIVE:
    - If mode_req_i is valid and differs from active_sel: target<=mode_req_i, drain_cnt<=0, go to DRAIN.
  - DRAIN:
    - drain_cnt increments every cycle.
    - If mode_req_i==active_sel: abort back to ACTIVE with no quiet period.
    - Else if mode_req_i is valid: target<=mode_req_i.
    - Exit to QUIET when eng_busy_i[active_sel]=0 and no valid is pending, i.e. rx_desc_wvalid_o=0 and rx_wvalid_o=0 (quiet_cnt<=0).
    - Exit to QUIET when drain_cnt reaches DrainTimeout-1, pulsing switch_timeout_o. Timeout has priority over abort.
  - QUIET:
    - quiet_cnt increments.
    - When quiet_cnt==QuietCycles-1: active_sel<=target, go to ACTIVE.
    - The new engine's eng_en_o rises in the first ACTIVE cycle.
    - Requests arriving during QUIET are evaluated in ACTIVE; no abort is possible.
- Handover length: at least QuietCycles+1 cycles from the DRAIN exit condition to the new owner driving the queues.
- A valid already asserted by the old owner in DRAIN is held by that engine until wready. The arbiter never drops a transfer that is accepted in DRAIN.
- Counter widths are $clog2(DrainTimeout+1) and $clog2(QuietCycles+1); neither counter wraps.

Test Plan:
- Reset with ResetEngine=0 and NumEngines=4 -> eng_en_o=4'b0001, active_sel_o=0, switch_pending_o=0; engine 0 rx_wvalid/wdata=0xA5 appears on rx_wvalid_o/rx_wdata_o in the same cycle.
- mode_req_i=2 while eng_busy_i[0]=1 for 10 cycles, then 0 -> DRAIN for 10 cycles; QUIET with eng_en_o=0 for 4 cycles; then eng_en_o=4'b0100 and active_sel_o=2.
- During DRAIN, mode_req_i returns to 0 -> next cycle state is ACTIVE, eng_en_o never drops, switch_timeout_o=0.
- eng_busy_i[0] held at 1 with DrainTimeout=16 -> switch_timeout_o pulses exactly once, 16 cycles after DRAIN entry, then QUIET and the switch completes.
- mode_req_i=5 with NumEngines=4 -> req_err_o=1 while applied, no state change; engine 1 rx_wvalid=1 never reaches rx_wvalid_o and eng_rx_wready_o[1]=0 throughout.
- rst_ni=0 during QUIET -> next cycle eng_en_o=one-hot(ResetEngine), state ACTIVE, counters cleared.
